// File: rtl/serv_rf_ram_ctrl_if.sv
// Bus bundle for serv_rf_ram_ctrl: serial core side plus word-wide RAM side.
// master = the controller, slave = the core/RAM environment.
interface serv_rf_ram_ctrl_if #(
  parameter int width    = 8,
  parameter int csr_regs = 4
);
  localparam int rw    = $clog2(32 + csr_regs);
  localparam int depth = 32 * (32 + csr_regs) / width;
  localparam int aw    = $clog2(depth);

  logic             i_rreq;
  logic [rw-1:0]    i_rreg0;
  logic [rw-1:0]    i_rreg1;
  logic             o_ready;
  logic             o_rdata0;
  logic             o_rdata1;
  logic             i_wreq;
  logic [rw-1:0]    i_wreg;
  logic             i_wen;
  logic             i_wdata;
  logic [aw-1:0]    o_waddr;
  logic [width-1:0] o_wdata;
  logic             o_wen;
  logic [aw-1:0]    o_raddr;
  logic             o_ren;
  logic [width-1:0] i_rdata;

  modport master (
    input  i_rreq, i_rreg0, i_rreg1, i_wreq, i_wreg, i_wen, i_wdata, i_rdata,
    output o_ready, o_rdata0, o_rdata1, o_waddr, o_wdata, o_wen, o_raddr, o_ren
  );

  modport slave (
    output i_rreq, i_rreg0, i_rreg1, i_wreq, i_wreg, i_wen, i_wdata, i_rdata,
    input  o_ready, o_rdata0, o_rdata1, o_waddr, o_wdata, o_wen, o_raddr, o_ren
  );
endinterface

// File: rtl/serv_rf_ram_ctrl.sv
// Serial register file to word RAM controller.
// Reads: prefetch two source registers and stream them out LSB first.
// Writes: deserialise one destination register and commit it word by word.
// Legal width: 4, 8, 16, 32.
// Optional build macro SERV_RF_X0_SUPPRESS_EN: drop every RAM write to x0.
//
// Read FSM states
//   state    | meaning
//   S_IDLE   | waiting for i_rreq
//   S_P0     | fetch word 0 of rreg0
//   S_P1     | fetch word 0 of rreg1, capture rreg0 word 0
//   S_P2     | capture rreg1 word 0, pulse o_ready
//   S_STREAM | 32 serial bits out, prefetching the following words
module serv_rf_ram_ctrl #(
  parameter int width    = 8,
  parameter int csr_regs = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  serv_rf_ram_ctrl_if.master  bus
);
  localparam int W     = 32 / width;
  localparam int lw    = $clog2(width);
  localparam int rw    = $clog2(32 + csr_regs);
  localparam int depth = 32 * (32 + csr_regs) / width;
  localparam int aw    = $clog2(depth);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_P0     = 3'd1;
  localparam logic [2:0] S_P1     = 3'd2;
  localparam logic [2:0] S_P2     = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;

  // reg*W + k equals {reg, k} since W is a power of two, and also works for W = 1.
  function automatic logic [aw-1:0] addr_of(input logic [rw-1:0] r, input logic [4:0] k);
    return aw'(r) * aw'(W) + aw'(k);
  endfunction

  // ---------------- read side ----------------
  logic [2:0]       rstate;
  logic [rw-1:0]    rreg0, rreg1;
  logic [4:0]       bcnt;
  logic [width-1:0] sh0, sh1, nx0, nx1;
  logic             cap0, cap1;
  logic [4:0]       rk, rbm;
  logic             more_words;
  logic             ren;
  logic [aw-1:0]    raddr;

  assign rk         = bcnt >> lw;
  assign rbm        = bcnt & 5'(width - 1);
  assign more_words = (int'(rk) < W - 1);

  // RAM read address/enable for the prefetch and in-stream next-word reads.
  always_comb begin
    ren   = 1'b0;
    raddr = '0;
    case (rstate)
      S_P0: begin
        ren   = 1'b1;
        raddr = addr_of(rreg0, 5'd0);
      end
      S_P1: begin
        ren   = 1'b1;
        raddr = addr_of(rreg1, 5'd0);
      end
      S_STREAM: begin
        if (more_words && rbm == 5'd0) begin
          ren   = 1'b1;
          raddr = addr_of(rreg0, 5'(rk + 5'd1));
        end else if (more_words && rbm == 5'd1) begin
          ren   = 1'b1;
          raddr = addr_of(rreg1, 5'(rk + 5'd1));
        end
      end
      default: ;
    endcase
  end

  // Read FSM, shift registers and next-word capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rstate <= S_IDLE;
      rreg0  <= '0;
      rreg1  <= '0;
      bcnt   <= '0;
      sh0    <= '0;
      sh1    <= '0;
      nx0    <= '0;
      nx1    <= '0;
      cap0   <= 1'b0;
      cap1   <= 1'b0;
    end else begin
      cap0 <= (rstate == S_STREAM) && ren && (rbm == 5'd0);
      cap1 <= (rstate == S_STREAM) && ren && (rbm == 5'd1);
      if (cap0) nx0 <= bus.i_rdata;
      if (cap1) nx1 <= bus.i_rdata;
      case (rstate)
        S_IDLE: begin
          if (bus.i_rreq) begin
            rreg0  <= bus.i_rreg0;
            rreg1  <= bus.i_rreg1;
            rstate <= S_P0;
          end
        end
        S_P0: rstate <= S_P1;
        S_P1: begin
          sh0    <= bus.i_rdata;
          rstate <= S_P2;
        end
        S_P2: begin
          sh1    <= bus.i_rdata;
          bcnt   <= '0;
          rstate <= S_STREAM;
        end
        S_STREAM: begin
          if (rbm == 5'(width - 1)) begin
            sh0 <= nx0;
            sh1 <= nx1;
          end else begin
            sh0 <= {1'b0, sh0[width-1:1]};
            sh1 <= {1'b0, sh1[width-1:1]};
          end
          bcnt <= bcnt + 5'd1;
          if (bcnt == 5'd31) rstate <= S_IDLE;
        end
        default: rstate <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ren    = ren;
  assign bus.o_raddr  = raddr;
  assign bus.o_ready  = (rstate == S_P2);
  assign bus.o_rdata0 = (rstate == S_STREAM) & sh0[0];
  assign bus.o_rdata1 = (rstate == S_STREAM) & sh1[0];

  // ---------------- write side ----------------
  logic             wactive;
  logic [rw-1:0]    wreg;
  logic [4:0]       wcnt;
  logic [width-2:0] wsh;
  logic [width-1:0] wword;
  logic [4:0]       wk, wbm;
  logic             wen_ok;
  logic             wen_q;
  logic [aw-1:0]    waddr_q;
  logic [width-1:0] wdata_q;

  assign wword = {bus.i_wdata, wsh};
  assign wk    = wcnt >> lw;
  assign wbm   = wcnt & 5'(width - 1);

`ifdef SERV_RF_X0_SUPPRESS_EN
  assign wen_ok = (wreg != '0);
`else
  assign wen_ok = 1'b1;
`endif

  // Write deserialiser; a word commits on the cycle after its last bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wactive <= 1'b0;
      wreg    <= '0;
      wcnt    <= '0;
      wsh     <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= 1'b0;
      if (!wactive) begin
        if (bus.i_wreq) begin
          wactive <= 1'b1;
          wreg    <= bus.i_wreg;
          wcnt    <= '0;
        end
      end else if (bus.i_wen) begin
        wsh  <= wword[width-1:1];
        wcnt <= wcnt + 5'd1;
        if (wbm == 5'(width - 1)) begin
          wen_q   <= wen_ok;
          waddr_q <= addr_of(wreg, wk);
          wdata_q <= wword;
        end
        if (wcnt == 5'd31) wactive <= 1'b0;
      end
    end
  end

  assign bus.o_wen   = wen_q;
  assign bus.o_waddr = waddr_q;
  assign bus.o_wdata = wdata_q;
endmodule

// File: tb/tb_serv_rf_ram_ctrl.sv
// Bench for serv_rf_ram_ctrl (width 8, 4 CSRs): register-level expectation
// schedule keyed by cycle number, plus literal pins on captured results.
module tb_serv_rf_ram_ctrl;
  localparam int WD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  serv_rf_ram_ctrl_if #(.width(WD), .csr_regs(4)) bus ();

  serv_rf_ram_ctrl #(.width(WD), .csr_regs(4)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // RAM: registered read with x0 zero gating, synchronous write.
  logic [7:0] mem [0:143];
  always @(posedge clk) begin
    if (bus.o_ren) bus.i_rdata <= (bus.o_raddr < 8'd4) ? 8'h00 : mem[bus.o_raddr];
    if (bus.o_wen) mem[bus.o_waddr] = bus.o_wdata;
  end

  // Register-level model and cycle-keyed expectations.
  logic [31:0] ref_reg [0:35];
  int          rd_free = 0;
  bit          w_busy = 1'b0;
  bit          exp_ready [int];
  bit          exp_rd0 [int];
  bit          exp_rd1 [int];
  int          exp_bi [int];
  bit          exp_wen [int];
  logic [7:0]  exp_wa [int];
  logic [7:0]  exp_wd [int];

  typedef struct { int c; int a; int d; } wrec_t;
  wrec_t       wlog [$];
  logic [31:0] cap0, cap1;
  int          rdy_cnt = 0;
  int          rdy_cyc = 0;
  int          req_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input int r);
    return (r == 0) ? 32'h0 : ref_reg[r];
  endfunction

  // Per-cycle comparison against the schedule.
  always @(negedge clk) begin
    logic er, e0, e1, ew;
    er = exp_ready.exists(cyc);
    e0 = exp_rd0.exists(cyc) ? exp_rd0[cyc] : 1'b0;
    e1 = exp_rd1.exists(cyc) ? exp_rd1[cyc] : 1'b0;
    ew = exp_wen.exists(cyc);
    chk("o_ready", 32'(bus.o_ready), 32'(er));
    chk("o_rdata0", 32'(bus.o_rdata0), 32'(e0));
    chk("o_rdata1", 32'(bus.o_rdata1), 32'(e1));
    chk("o_wen", 32'(bus.o_wen), 32'(ew));
    if (ew) begin
      chk("o_waddr", 32'(bus.o_waddr), 32'(exp_wa[cyc]));
      chk("o_wdata", 32'(bus.o_wdata), 32'(exp_wd[cyc]));
    end
    if (exp_bi.exists(cyc)) begin
      cap0[exp_bi[cyc]] = bus.o_rdata0;
      cap1[exp_bi[cyc]] = bus.o_rdata1;
    end
    if (bus.o_ready) begin
      rdy_cnt++;
      rdy_cyc = cyc;
    end
    if (bus.o_wen) wlog.push_back('{cyc, int'(bus.o_waddr), int'(bus.o_wdata)});
  end

  task automatic do_read(input int r0, input int r1);
    logic [31:0] v0, v1;
    @(posedge clk); #1;
    bus.i_rreq = 1'b1;
    bus.i_rreg0 = 6'(r0);
    bus.i_rreg1 = 6'(r1);
    if (cyc >= rd_free) begin
      v0 = reg_val(r0);
      v1 = reg_val(r1);
      req_cyc = cyc;
      rd_free = cyc + 36;
      exp_ready[cyc + 3] = 1'b1;
      for (int i = 0; i < 32; i++) begin
        exp_rd0[cyc + 4 + i] = v0[i];
        exp_rd1[cyc + 4 + i] = v1[i];
        exp_bi[cyc + 4 + i]  = i;
      end
    end
    @(posedge clk); #1;
    bus.i_rreq = 1'b0;
  endtask

  task automatic do_write(input int r, input logic [31:0] v, input int stall_at, input int stall_len);
    bit acc;
    @(posedge clk); #1;
    bus.i_wreq = 1'b1;
    bus.i_wreg = 6'(r);
    acc = !w_busy;
    if (acc) begin
      w_busy = 1'b1;
      if (r != 0) ref_reg[r] = v;
    end
    @(posedge clk); #1;
    bus.i_wreq = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j == stall_at) begin
        bus.i_wen = 1'b0;
        repeat (stall_len) begin @(posedge clk); #1; end
      end
      bus.i_wen = 1'b1;
      bus.i_wdata = v[j];
      if (acc && (j % WD) == WD - 1) begin
`ifdef SERV_RF_X0_SUPPRESS_EN
        if (r != 0) begin
`else
        begin
`endif
          exp_wen[cyc + 1] = 1'b1;
          exp_wa[cyc + 1]  = 8'(r * 4 + j / WD);
          exp_wd[cyc + 1]  = v[(j / WD) * WD +: WD];
        end
      end
      @(posedge clk); #1;
    end
    bus.i_wen = 1'b0;
    bus.i_wdata = 1'b0;
    if (acc) w_busy = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".ready"}, 32'(bus.o_ready), 32'h0);
    chk({tag, ".rdata0"}, 32'(bus.o_rdata0), 32'h0);
    chk({tag, ".rdata1"}, 32'(bus.o_rdata1), 32'h0);
    chk({tag, ".wen"}, 32'(bus.o_wen), 32'h0);
    chk({tag, ".ren"}, 32'(bus.o_ren), 32'h0);
    chk({tag, ".raddr"}, 32'(bus.o_raddr), 32'h0);
    chk({tag, ".waddr"}, 32'(bus.o_waddr), 32'h0);
    chk({tag, ".wdata"}, 32'(bus.o_wdata), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pre5, pre7;
    pre5 = 32'h12345678;
    pre7 = 32'h9ABCDEF0;
    bus.i_rreq = 0; bus.i_rreg0 = 0; bus.i_rreg1 = 0;
    bus.i_wreq = 0; bus.i_wreg = 0; bus.i_wen = 0; bus.i_wdata = 0;
    bus.i_rdata = '0;
    for (int r = 0; r < 36; r++) ref_reg[r] = 32'h0;
    for (int a = 0; a < 144; a++) mem[a] = 8'h00;
    ref_reg[5] = pre5;
    ref_reg[7] = pre7;
    for (int k = 0; k < 4; k++) begin
      mem[5 * 4 + k] = pre5[k * 8 +: 8];
      mem[7 * 4 + k] = pre7[k * 8 +: 8];
    end

    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Read x5/x7.
    cap0 = 0; cap1 = 0;
    do_read(5, 7);
    repeat (40) @(posedge clk);
    chk("rd57.rdata0_word", cap0, 32'h12345678);
    chk("rd57.rdata1_word", cap1, 32'h9ABCDEF0);
    chk("rd57.ready_latency", 32'(rdy_cyc - req_cyc), 32'd3);

    // Continuous write x3.
    wlog.delete();
    do_write(3, 32'hA5A50F0F, -1, 0);
    repeat (3) @(posedge clk);
    chk("wr3.count", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("wr3.addr0", 32'(wlog[0].a), 32'd12);
      chk("wr3.addr3", 32'(wlog[3].a), 32'd15);
      chk("wr3.data0", 32'(wlog[0].d), 32'h0F);
      chk("wr3.data1", 32'(wlog[1].d), 32'h0F);
      chk("wr3.data2", 32'(wlog[2].d), 32'hA5);
      chk("wr3.data3", 32'(wlog[3].d), 32'hA5);
      chk("wr3.gap", 32'(wlog[1].c - wlog[0].c), 32'd8);
    end

    // Same write with a 3-cycle stall inside word 1.
    wlog.delete();
    do_write(3, 32'hA5A50F0F, 12, 3);
    repeat (3) @(posedge clk);
    chk("wrstall.count", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("wrstall.gap1", 32'(wlog[1].c - wlog[0].c), 32'd11);
      chk("wrstall.gap2", 32'(wlog[2].c - wlog[1].c), 32'd8);
      chk("wrstall.data2", 32'(wlog[2].d), 32'hA5);
    end

    // Write to x0.
    wlog.delete();
    do_write(0, 32'hFFFFFFFF, -1, 0);
    repeat (3) @(posedge clk);
`ifdef SERV_RF_X0_SUPPRESS_EN
    chk("wrx0.count", 32'(wlog.size()), 32'd0);
`else
    chk("wrx0.count", 32'(wlog.size()), 32'd4);
`endif

    // Reset at stream bit 10 (read requested in cycle c, bit 10 in c+14).
    do_read(5, 7);
    repeat (13) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_ready.delete(); exp_rd0.delete(); exp_rd1.delete(); exp_bi.delete();
    exp_wen.delete(); exp_wa.delete(); exp_wd.delete();
    rd_free = 0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cap0 = 0; cap1 = 0;
    do_read(7, 5);
    repeat (40) @(posedge clk);
    chk("rdpost.rdata0_word", cap0, 32'h9ABCDEF0);
    chk("rdpost.rdata1_word", cap1, 32'h12345678);

    // Simultaneous read x5/x0 and write x9, with ignored second requests.
    cap0 = 0; cap1 = 0;
    rdy_cnt = 0;
    fork
      begin
        do_read(5, 0);
        repeat (15) @(posedge clk);
        do_read(9, 3);
      end
      begin
        do_write(9, 32'hC3A15E27, -1, 0);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        bus.i_wreq = 1'b1;
        bus.i_wreg = 6'd11;
        @(posedge clk); #1;
        bus.i_wreq = 1'b0;
      end
    join
    repeat (30) @(posedge clk);
    chk("sim.ready_count", 32'(rdy_cnt), 32'd1);
    chk("sim.rdata0_word", cap0, 32'h12345678);
    chk("sim.rdata1_word", cap1, 32'h0);

    // Read back what the concurrent write left in the RAM.
    cap0 = 0; cap1 = 0;
    do_read(9, 3);
    repeat (40) @(posedge clk);
    chk("rb.rdata0_word", cap0, 32'hC3A15E27);
    chk("rb.rdata1_word", cap1, 32'hA5A50F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
